// File: rtl/alu_bus_sequencer_if.sv
// Bus-side signal bundle between the instruction controller / ALU environment and alu_bus_sequencer.
// master = the sequencer, slave = the controller/ALU side that drives operands and reads results.
interface alu_bus_sequencer_if #(
    parameter int REG_WIDTH = 8
);
    logic                 start;
    logic [2:0]           fn_in;
    logic                 src_valid;
    logic [REG_WIDTH-1:0] bus;
    logic                 req_a;
    logic                 req_b;
    logic [REG_WIDTH-1:0] reg_A;
    logic [REG_WIDTH-1:0] reg_B;
    logic [2:0]           fn;
    logic                 alu_en;
    logic                 busy;
    logic                 done;
    logic [REG_WIDTH-1:0] result;
    logic                 flag_zero;
    logic                 flag_neg;
    logic                 div0_err;

    modport master (
        input  start, fn_in, src_valid, bus,
        output req_a, req_b, reg_A, reg_B, fn, alu_en, busy, done,
               result, flag_zero, flag_neg, div0_err
    );

    modport slave (
        output start, fn_in, src_valid, bus,
        input  req_a, req_b, reg_A, reg_B, fn, alu_en, busy, done,
               result, flag_zero, flag_neg, div0_err
    );
endinterface

// File: rtl/alu_bus_sequencer.sv
// Loads ALU operands off the shared bus, runs one ALU cycle and captures the result and flags.
// Optional macro ALU_DIV0_TRAP_EN: short-circuits divide-by-zero to an all-ones result with div0_err.
module alu_bus_sequencer #(
    parameter int REG_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    alu_bus_sequencer_if.master   alu_bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        READ   = 3'd4
    } state_t;

    localparam logic [2:0] FN_DIV = 3'b011;

    state_t state;
    state_t state_nxt;

    logic latch_fn;
    logic cap_a;
    logic cap_b;
    logic cap_res;
    logic trap;
    logic div0_hit;

`ifdef ALU_DIV0_TRAP_EN
    assign div0_hit = (alu_bus.fn == FN_DIV) && (alu_bus.bus == '0);
`else
    assign div0_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        latch_fn  = 1'b0;
        cap_a     = 1'b0;
        cap_b     = 1'b0;
        cap_res   = 1'b0;
        trap      = 1'b0;
        case (state)
            IDLE: begin
                if (alu_bus.start) begin
                    latch_fn  = 1'b1;
                    state_nxt = LOAD_A;
                end
            end
            LOAD_A: begin
                if (alu_bus.src_valid) begin
                    cap_a     = 1'b1;
                    state_nxt = LOAD_B;
                end
            end
            LOAD_B: begin
                if (alu_bus.src_valid) begin
                    cap_b = 1'b1;
                    // A trapped divide never reaches the ALU, so EXEC/READ are skipped.
                    if (div0_hit) begin
                        trap      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = EXEC;
                    end
                end
            end
            EXEC: begin
                state_nxt = READ;
            end
            READ: begin
                cap_res   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign alu_bus.req_a  = (state == LOAD_A);
    assign alu_bus.req_b  = (state == LOAD_B);
    assign alu_bus.alu_en = (state == READ);
    assign alu_bus.busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (clr) begin
            alu_bus.fn        <= '0;
            alu_bus.reg_A     <= '0;
            alu_bus.reg_B     <= '0;
            alu_bus.result    <= '0;
            alu_bus.flag_zero <= 1'b0;
            alu_bus.flag_neg  <= 1'b0;
            alu_bus.done      <= 1'b0;
        end else begin
            alu_bus.done <= cap_res | trap;
            if (latch_fn) begin
                alu_bus.fn <= alu_bus.fn_in;
            end
            if (cap_a) begin
                alu_bus.reg_A <= alu_bus.bus;
            end
            if (cap_b) begin
                alu_bus.reg_B <= alu_bus.bus;
            end
            if (cap_res) begin
                alu_bus.result    <= alu_bus.bus;
                alu_bus.flag_zero <= (alu_bus.bus == '0);
                alu_bus.flag_neg  <= alu_bus.bus[REG_WIDTH-1];
            end else if (trap) begin
                alu_bus.result    <= '1;
                alu_bus.flag_zero <= 1'b0;
                alu_bus.flag_neg  <= 1'b1;
            end
        end
    end

`ifdef ALU_DIV0_TRAP_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            alu_bus.div0_err <= 1'b0;
        end else if (trap) begin
            alu_bus.div0_err <= 1'b1;
        end else if (cap_res) begin
            alu_bus.div0_err <= 1'b0;
        end
    end
`else
    assign alu_bus.div0_err = 1'b0;
`endif

endmodule
